proc_run_controller: RTL and testbench
======================================

Name: proc_run_controller

Overview:
- Top-level run sequencer for the single-cycle RISC-V core.
- Owns the processor's life cycle: program load into instruction memory, run, memory-wait stall, normal completion and fault.
- Drives `enable` into the control unit and the PC enable/clear, and consumes the control unit's `error`/`endProcess`/`memRead`/`memWrite` outputs.
- Adds a cycle watchdog, a data-memory wait timeout and a retired-instruction counter.

Parameters:
- COUNT_W, 32, width of instr_count and watchdog counter
- WATCHDOG_CYCLES, 1000000, max cycles in RUN+MEM_WAIT per run before timeout fault
- MEM_WAIT_MAX, 16, max consecutive MEM_WAIT cycles before memory timeout fault

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request, level-sampled
- abort  in  1  return to IDLE from any state
- load_req  in  1  program-load request from loader
- load_done  in  1  loader finished writing imem
- cu_error  in  1  illegal opcode from control unit
- cu_end_process  in  1  end-of-program from control unit
- cu_mem_read  in  1  control unit memRead
- cu_mem_write  in  1  control unit memWrite
- mem_busy  in  1  data memory not ready this cycle
- cpu_enable  out  1  to control unit enable
- pc_enable  out  1  PC update strobe
- pc_clear  out  1  PC reset to 0
- imem_load_sel  out  1  imem write port owned by loader
- busy  out  1  state is RUN or MEM_WAIT
- done  out  1  state is DONE
- fault  out  1  state is FAULT
- fault_code  out  2  00 none, 01 illegal op, 10 watchdog, 11 mem timeout
- instr_count  out  COUNT_W  retired instructions this run

Behaviour:
Reset (rst=1 at edge):
- state goes to IDLE; prog_valid, instr_count, watchdog count, wait count and fault_code all 0.
- All outputs are 0 in the cycle after reset.
- Reset mid-run discards everything, including prog_valid.

State machine: IDLE, LOAD, RUN, MEM_WAIT, DONE, FAULT.
- Outputs are Moore decodes of state, except pc_enable and pc_clear.
- Priority within a cycle: rst > abort > cu_error > watchdog expiry > mem timeout > cu_end_process > stall.

IDLE:
- If load_req, go to LOAD; load_req wins over start in the same cycle.
- Else if start and prog_valid: pc_clear=1 this cycle; clear instr_count, watchdog, wait count and fault_code; go to RUN.
- start with prog_valid=0 is ignored and the state stays IDLE.

LOAD:
- imem_load_sel=1.
- On load_done: prog_valid<=1, go to IDLE.
- abort in LOAD: go to IDLE with prog_valid<=0.

RUN:
- cpu_enable=1.
- mem_access = cu_mem_read | cu_mem_write.
- pc_enable = !(mem_access & mem_busy) & !cu_error & !cu_end_process.
- Watchdog increments every RUN/MEM_WAIT cycle; when it reaches WATCHDOG_CYCLES-1 in either state, go to FAULT with code 10.
- If cu_error: go to FAULT with code 01; the PC does not advance.
- Else if cu_end_process: go to DONE; that instruction is not counted.
- Else if mem_access & mem_busy: go to MEM_WAIT, wait count <= 1.

MEM_WAIT:
- cpu_enable=1, so the control unit keeps its memory request asserted.
- pc_enable = !mem_busy.
- When mem_busy=0: count the instruction, wait count <= 0, go to RUN.
- If still busy with wait count == MEM_WAIT_MAX-1: go to FAULT with code 11.
- Otherwise wait count increments.

instr_count:
- Increments on every cycle with pc_enable=1.
- Saturates at all-ones; no wrap.

DONE:
- Counters hold.
- start (prog_valid is still 1): pc_clear=1, counters clear, go to RUN.
- load_req: go to LOAD.

FAULT:
- Sticky; fault_code and instr_count hold.
- start and load_req are ignored; only abort or rst leave FAULT.

abort in any state:
- Go to IDLE; fault_code <= 0; cpu_enable and pc_enable are 0 that cycle.
- prog_valid is kept, except when aborting from LOAD.

Decomposition:
- Shared package `definitions` gains:
  - `run_state_t` enum (IDLE, LOAD, RUN, MEM_WAIT, DONE, FAULT)
  - `fault_code_t` enum (FC_NONE, FC_ILLEGAL, FC_WATCHDOG, FC_MEM_TIMEOUT)
- One sub-module is natural: `sat_counter`, parameterised width, with clear, inc and saturation.
  - Instantiated three times: instr_count, watchdog, mem wait.

Test Plan:
1. rst, start=1 with no load -> state stays IDLE, cpu_enable=0. Then load_req, then load_done after 5 cycles -> imem_load_sel=1 for those cycles, then IDLE. Then start -> pc_clear=1 for one cycle, busy=1 the next.
2. Run with cu_end_process raised on the 10th RUN cycle -> done=1, instr_count=9, fault_code=00. Then start again -> instr_count resets to 0 and counts from 0.
3. In RUN, cu_mem_read=1 and mem_busy=1 for 3 cycles -> pc_enable low for those 3 cycles, one MEM_WAIT exit, instr_count +1 only on release. With MEM_WAIT_MAX=4 and mem_busy held 4 cycles -> fault=1, fault_code=11.
4. cu_error asserted together with cu_end_process -> FAULT, code 01, pc_enable=0 that cycle. A following start is ignored; abort -> IDLE, fault_code=00, prog_valid still 1.
5. WATCHDOG_CYCLES=20 with no end_process -> fault_code=10 on the 20th busy cycle, instr_count=19.
6. rst mid-RUN -> all outputs 0 next cycle. start afterwards is ignored because prog_valid=0.

Source files
------------

// File: rtl/proc_run_controller_pkg.sv
// Shared types for the run sequencer: life-cycle states and fault reason codes.
package proc_run_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        MEM_WAIT,
        DONE,
        FAULT
    } run_state_t;

    typedef enum logic [1:0] {
        FC_NONE        = 2'b00,
        FC_ILLEGAL     = 2'b01,
        FC_WATCHDOG    = 2'b10,
        FC_MEM_TIMEOUT = 2'b11
    } fault_code_t;

endpackage

// File: rtl/proc_run_controller_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/proc_run_controller.sv
// Run sequencer for the single-cycle core: load, run, memory stall, completion,
// fault, plus a run watchdog, a memory wait timeout and a retired-instruction count.
module proc_run_controller
    import proc_run_controller_pkg::*;
#(
    parameter int COUNT_W         = 32,
    parameter int WATCHDOG_CYCLES = 1000000,
    parameter int MEM_WAIT_MAX    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               load_req,
    input  logic               load_done,
    input  logic               cu_error,
    input  logic               cu_end_process,
    input  logic               cu_mem_read,
    input  logic               cu_mem_write,
    input  logic               mem_busy,
    output logic               cpu_enable,
    output logic               pc_enable,
    output logic               pc_clear,
    output logic               imem_load_sel,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    run_state_t        state, state_n;
    fault_code_t       fault_q, fault_val;
    logic              fault_set;
    logic              prog_valid;
    logic [COUNT_W-1:0] wd_count;
    logic [WAIT_W-1:0]  wait_count;
    logic              mem_access, wd_expire, wait_expire, running;

    assign mem_access  = cu_mem_read | cu_mem_write;
    assign running     = (state == RUN) || (state == MEM_WAIT);
    assign wd_expire   = (wd_count == COUNT_W'(WATCHDOG_CYCLES - 1));
    assign wait_expire = (wait_count == WAIT_W'(MEM_WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fault_q    <= FC_NONE;
            prog_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (abort || pc_clear) begin
                fault_q <= FC_NONE;
            end else if (fault_set) begin
                fault_q <= fault_val;
            end
            // Aborting a load leaves imem half-written, so the program is no longer trusted.
            if (state == LOAD) begin
                if (abort) begin
                    prog_valid <= 1'b0;
                end else if (load_done) begin
                    prog_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n   = state;
        pc_enable = 1'b0;
        pc_clear  = 1'b0;
        fault_set = 1'b0;
        fault_val = FC_NONE;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load_req) begin
                        state_n = LOAD;
                    end else if (start && prog_valid) begin
                        pc_clear = 1'b1;
                        state_n  = RUN;
                    end
                end
                LOAD: begin
                    if (load_done) state_n = IDLE;
                end
                RUN: begin
                    pc_enable = !(mem_access && mem_busy) && !cu_error && !cu_end_process && !wd_expire;
                    if (cu_error) begin
                        fault_set = 1'b1;
                        fault_val = FC_ILLEGAL;
                        state_n   = FAULT;
                    end else if (wd_expire) begin
                        fault_set = 1'b1;
                        fault_val = FC_WATCHDOG;
                        state_n   = FAULT;
                    end else if (cu_end_process) begin
                        state_n = DONE;
                    end else if (mem_access && mem_busy) begin
                        state_n = MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    pc_enable = !mem_busy && !cu_error && !wd_expire;
                    if (cu_error) begin
                        fault_set = 1'b1;
                        fault_val = FC_ILLEGAL;
                        state_n   = FAULT;
                    end else if (wd_expire) begin
                        fault_set = 1'b1;
                        fault_val = FC_WATCHDOG;
                        state_n   = FAULT;
                    end else if (mem_busy && wait_expire) begin
                        fault_set = 1'b1;
                        fault_val = FC_MEM_TIMEOUT;
                        state_n   = FAULT;
                    end else if (!mem_busy) begin
                        state_n = RUN;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    sat_counter #(.W(COUNT_W)) u_instr_count (
        .clk(clk), .rst(rst), .clr(pc_clear), .inc(pc_enable), .count(instr_count)
    );

    sat_counter #(.W(COUNT_W)) u_watchdog (
        .clk(clk), .rst(rst), .clr(pc_clear), .inc(running && !abort), .count(wd_count)
    );

    // Counts stall cycles while heading into or staying in MEM_WAIT, zero otherwise.
    sat_counter #(.W(WAIT_W)) u_wait_count (
        .clk(clk), .rst(rst), .clr(state_n != MEM_WAIT), .inc(state_n == MEM_WAIT),
        .count(wait_count)
    );

    assign cpu_enable    = running && !abort;
    assign busy          = running;
    assign done          = (state == DONE);
    assign fault         = (state == FAULT);
    assign imem_load_sel = (state == LOAD);
    assign fault_code    = fault_q;

endmodule

// File: tb/tb_proc_run_controller.sv
// Vector-table bench for proc_run_controller with a queue of registered-output expectations.
module tb_proc_run_controller;

    localparam int CW = 32;

    localparam logic [8:0] S  = 9'h100;
    localparam logic [8:0] A  = 9'h080;
    localparam logic [8:0] LR = 9'h040;
    localparam logic [8:0] LD = 9'h020;
    localparam logic [8:0] ER = 9'h010;
    localparam logic [8:0] EP = 9'h008;
    localparam logic [8:0] RD = 9'h004;
    localparam logic [8:0] WR = 9'h002;
    localparam logic [8:0] MB = 9'h001;

    // {cpu_enable, busy, done, fault, imem_load_sel}
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_LOAD = 5'b00001;
    localparam logic [4:0] O_RUN  = 5'b11000;
    localparam logic [4:0] O_DONE = 5'b00100;
    localparam logic [4:0] O_FLT  = 5'b00010;

    typedef struct {
        string       nm;
        logic [8:0]  in;
        logic        pce;
        logic        pcc;
        logic [4:0]  o;
        logic [1:0]  fc;
        logic [CW-1:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, load_req = 1'b0, load_done = 1'b0;
    logic cu_error = 1'b0, cu_end_process = 1'b0, cu_mem_read = 1'b0, cu_mem_write = 1'b0;
    logic mem_busy = 1'b0;
    logic cpu_enable, pc_enable, pc_clear, imem_load_sel, busy, done, fault;
    logic [1:0] fault_code;
    logic [CW-1:0] instr_count;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    vec_t sb[$];

    proc_run_controller #(
        .COUNT_W(CW), .WATCHDOG_CYCLES(20), .MEM_WAIT_MAX(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .load_req(load_req),
        .load_done(load_done), .cu_error(cu_error), .cu_end_process(cu_end_process),
        .cu_mem_read(cu_mem_read), .cu_mem_write(cu_mem_write), .mem_busy(mem_busy),
        .cpu_enable(cpu_enable), .pc_enable(pc_enable), .pc_clear(pc_clear),
        .imem_load_sel(imem_load_sel), .busy(busy), .done(done), .fault(fault),
        .fault_code(fault_code), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [8:0] in, input logic pce, input logic pcc,
                       input logic [4:0] o, input logic [1:0] fc, input logic [CW-1:0] cnt);
        vec_t v;
        v.nm = nm; v.in = in; v.pce = pce; v.pcc = pcc; v.o = o; v.fc = fc; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        {start, abort, load_req, load_done, cu_error, cu_end_process,
         cu_mem_read, cu_mem_write, mem_busy} = v.in;
        #1;
        chk({v.nm, ".pc_enable"}, CW'(pc_enable), CW'(v.pce));
        chk({v.nm, ".pc_clear"}, CW'(pc_clear), CW'(v.pcc));
        sb.push_back(v);
    endtask

    task automatic run_table();
        foreach (tbl[i]) drive(tbl[i]);
        tbl.delete();
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        {start, abort, load_req, load_done, cu_error, cu_end_process,
         cu_mem_read, cu_mem_write, mem_busy} = '0;
        @(posedge clk);
        #1;
        chk({nm, ".flags"}, CW'({cpu_enable, busy, done, fault, imem_load_sel}), '0);
        chk({nm, ".pc"}, CW'({pc_enable, pc_clear}), '0);
        chk({nm, ".fault_code"}, CW'(fault_code), '0);
        chk({nm, ".instr_count"}, instr_count, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        vec_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.nm, ".flags"}, CW'({cpu_enable, busy, done, fault, imem_load_sel}), CW'(e.o));
            chk({e.nm, ".fault_code"}, CW'(fault_code), CW'(e.fc));
            chk({e.nm, ".instr_count"}, instr_count, e.cnt);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        do_reset("reset");

        // Program load and first start
        add("start_noprog", S, 0, 0, O_IDLE, 0, 0);
        add("load_req", LR, 0, 0, O_LOAD, 0, 0);
        for (int i = 0; i < 4; i++) add("load_wait", '0, 0, 0, O_LOAD, 0, 0);
        add("load_done", LD, 0, 0, O_IDLE, 0, 0);
        add("start", S, 0, 1, O_RUN, 0, 0);
        // End of program on the 10th RUN cycle
        for (int k = 1; k <= 9; k++) add("run", '0, 1, 0, O_RUN, 0, CW'(k));
        add("end_process", EP, 0, 0, O_DONE, 0, 9);
        add("restart", S, 0, 1, O_RUN, 0, 0);
        add("run2a", '0, 1, 0, O_RUN, 0, 1);
        add("run2b", '0, 1, 0, O_RUN, 0, 2);
        // Three-cycle memory stall then release
        add("stall_run", RD | MB, 0, 0, O_RUN, 0, 2);
        add("stall_w1", RD | MB, 0, 0, O_RUN, 0, 2);
        add("stall_w2", RD | MB, 0, 0, O_RUN, 0, 2);
        add("stall_rel", RD, 1, 0, O_RUN, 0, 3);
        add("run3", '0, 1, 0, O_RUN, 0, 4);
        // Memory held busy for MEM_WAIT_MAX cycles
        add("mto_run", WR | MB, 0, 0, O_RUN, 0, 4);
        add("mto_w1", WR | MB, 0, 0, O_RUN, 0, 4);
        add("mto_w2", WR | MB, 0, 0, O_RUN, 0, 4);
        add("mto_w3", WR | MB, 0, 0, O_FLT, 3, 4);
        add("mto_hold", '0, 0, 0, O_FLT, 3, 4);
        add("abort_mto", A, 0, 0, O_IDLE, 0, 4);
        // Illegal opcode beats end-of-program
        add("start4", S, 0, 1, O_RUN, 0, 0);
        add("err_end", ER | EP, 0, 0, O_FLT, 1, 0);
        add("flt_start", S, 0, 0, O_FLT, 1, 0);
        add("flt_load", LR, 0, 0, O_FLT, 1, 0);
        add("flt_abort", A, 0, 0, O_IDLE, 0, 0);
        add("start5", S, 0, 1, O_RUN, 0, 0);
        // Watchdog trips on the 20th busy cycle
        for (int k = 1; k <= 19; k++) add("wd_run", '0, 1, 0, O_RUN, 0, CW'(k));
        add("wd_trip", '0, 0, 0, O_FLT, 2, 19);
        add("wd_abort", A, 0, 0, O_IDLE, 0, 19);
        add("start6", S, 0, 1, O_RUN, 0, 0);
        for (int k = 1; k <= 3; k++) add("run6", '0, 1, 0, O_RUN, 0, CW'(k));
        run_table();

        // Reset mid-run drops prog_valid
        do_reset("reset_midrun");
        add("start_after_rst", S, 0, 0, O_IDLE, 0, 0);
        add("reload_req", LR, 0, 0, O_LOAD, 0, 0);
        add("reload_done", LD, 0, 0, O_IDLE, 0, 0);
        add("load_beats_start", S | LR, 0, 0, O_LOAD, 0, 0);
        add("abort_load", A, 0, 0, O_IDLE, 0, 0);
        add("start_abortload", S, 0, 0, O_IDLE, 0, 0);
        run_table();

        begin
            int guard = 0;
            while (sb.size() > 0 && guard < 5) begin
                @(posedge clk);
                guard++;
            end
            #2;
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d pending expected 0", sb.size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
